// File: rtl/i2c_req_arbiter_if.sv
// Bundle of requester-side and I2C-master-side signals around the arbiter.
// The arbiter connects through the master modport; the environment connects through slave.
interface i2c_req_arbiter_if #(
   parameter int N_REQ = 4
) ();
   logic [N_REQ-1:0]   req;
   logic [7*N_REQ-1:0] req_addr;
   logic [N_REQ-1:0]   req_op;
   logic [8*N_REQ-1:0] req_wdata;
   logic [N_REQ-1:0]   gnt;
   logic [N_REQ-1:0]   rsp_valid;
   logic [7:0]         rsp_rdata;
   logic               rsp_err;
   logic               rsp_timeout;
   logic               arb_busy;
   logic               m_newd;
   logic [6:0]         m_addr;
   logic               m_op;
   logic [7:0]         m_din;
   logic [7:0]         m_dout;
   logic               m_busy;
   logic               m_done;
   logic               m_ack_err;

   modport master (
      input  req, req_addr, req_op, req_wdata, m_dout, m_busy, m_done, m_ack_err,
      output gnt, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, arb_busy,
             m_newd, m_addr, m_op, m_din
   );

   modport slave (
      output req, req_addr, req_op, req_wdata, m_dout, m_busy, m_done, m_ack_err,
      input  gnt, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, arb_busy,
             m_newd, m_addr, m_op, m_din
   );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one I2C master engine between N_REQ requesters,
// launching one transaction per grant and returning read data / status to the winner.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no transaction; arbitrate among req, latch winner's fields
// ISSUE     | winner latched; m_newd asserted on exit, timeout cleared
// WAIT_BUSY | launched; waiting for the engine to show busy (or finish)
// WAIT_DONE | engine busy; waiting for m_done or timeout
// RESPOND   | rsp_valid to the winner; advance round-robin pointer
module i2c_req_arbiter #(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = 40000
) (
   input logic             clk,
   input logic             rst,
   i2c_req_arbiter_if.master bus
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IW:0] N_W = (IW+1)'(N_REQ);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] ISSUE     = 3'd1;
   localparam logic [2:0] WAIT_BUSY = 3'd2;
   localparam logic [2:0] WAIT_DONE = 3'd3;
   localparam logic [2:0] RESPOND   = 3'd4;

   logic [2:0]       state_q,       state_d;
   logic [IW-1:0]    rr_ptr_q,      rr_ptr_d;
   logic [IW-1:0]    win_q,         win_d;
   logic [CW-1:0]    cnt_q,         cnt_d;
   logic [N_REQ-1:0] gnt_q,         gnt_d;
   logic [N_REQ-1:0] rsp_valid_q,   rsp_valid_d;
   logic [7:0]       rsp_rdata_q,   rsp_rdata_d;
   logic             rsp_err_q,     rsp_err_d;
   logic             rsp_timeout_q, rsp_timeout_d;
   logic             arb_busy_q,    arb_busy_d;
   logic             m_newd_q,      m_newd_d;
   logic [6:0]       m_addr_q,      m_addr_d;
   logic             m_op_q,        m_op_d;
   logic [7:0]       m_din_q,       m_din_d;

   logic            found;
   logic [IW-1:0]   pick;
   logic [IW:0]     sum;
   logic [IW-1:0]   idx;
   logic [6:0]      addr_sel;
   logic            op_sel;
   logic [7:0]      wdata_sel;

   // Scan from rr_ptr upward with wrap; the first requester found wins.
   always_comb begin
      found     = 1'b0;
      pick      = '0;
      sum       = '0;
      idx       = '0;
      addr_sel  = '0;
      op_sel    = 1'b0;
      wdata_sel = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
         if (sum >= N_W) sum = sum - N_W;
         idx = sum[IW-1:0];
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (IW'(i) == pick) begin
            addr_sel  = bus.req_addr[i*7 +: 7];
            op_sel    = bus.req_op[i];
            wdata_sel = bus.req_wdata[i*8 +: 8];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      win_d         = win_q;
      cnt_d         = cnt_q;
      gnt_d         = gnt_q;
      rsp_valid_d   = '0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      m_newd_d      = 1'b0;
      m_addr_d      = m_addr_q;
      m_op_d        = m_op_q;
      m_din_d       = m_din_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d     = ISSUE;
               win_d       = pick;
               gnt_d       = '0;
               gnt_d[pick] = 1'b1;
               m_addr_d    = addr_sel;
               m_op_d      = op_sel;
               m_din_d     = wdata_sel;
            end
         end
         ISSUE: begin
            m_newd_d = 1'b1;
            cnt_d    = '0;
            state_d  = WAIT_BUSY;
         end
         WAIT_BUSY, WAIT_DONE: begin
            // Completion beats a timeout landing in the same cycle.
            if (bus.m_done) begin
               rsp_rdata_d   = m_op_q ? bus.m_dout : 8'h00;
               rsp_err_d     = bus.m_ack_err;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = gnt_q;
               state_d       = RESPOND;
            end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
               rsp_rdata_d   = 8'h00;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = gnt_q;
               state_d       = RESPOND;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (state_q == WAIT_BUSY && bus.m_busy) state_d = WAIT_DONE;
            end
         end
         RESPOND: begin
            gnt_d    = '0;
            rr_ptr_d = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + IW'(1);
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      arb_busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         win_q         <= '0;
         cnt_q         <= '0;
         gnt_q         <= '0;
         rsp_valid_q   <= '0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         arb_busy_q    <= 1'b0;
         m_newd_q      <= 1'b0;
         m_addr_q      <= '0;
         m_op_q        <= 1'b0;
         m_din_q       <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         win_q         <= win_d;
         cnt_q         <= cnt_d;
         gnt_q         <= gnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         arb_busy_q    <= arb_busy_d;
         m_newd_q      <= m_newd_d;
         m_addr_q      <= m_addr_d;
         m_op_q        <= m_op_d;
         m_din_q       <= m_din_d;
      end
   end

   assign bus.gnt         = gnt_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_timeout_q;
   assign bus.arb_busy    = arb_busy_q;
   assign bus.m_newd      = m_newd_q;
   assign bus.m_addr      = m_addr_q;
   assign bus.m_op        = m_op_q;
   assign bus.m_din       = m_din_q;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: directed scenarios then random transactions, each
// compared against a transaction-level round-robin / timing reference model.
module tb_i2c_req_arbiter;
   localparam int N  = 4;
   localparam int TO = 50;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   i2c_req_arbiter_if #(.N_REQ(N)) bus ();

   i2c_req_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors   = 0;
   int checks   = 0;
   int model_rr = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++)
         if (r[2'((p + k) % N)]) return (p + k) % N;
      return -1;
   endfunction

   task automatic set_fields(input int i, input logic [6:0] a, input logic op, input logic [7:0] wd);
      bus.req_addr[7*i +: 7]  = a;
      bus.req_op[i]           = op;
      bus.req_wdata[8*i +: 8] = wd;
   endtask

   // One transaction from grant to the IDLE cycle after the response.
   // k: cycle offset (0 = first cycle m_newd is seen) where m_done is driven, -1 = never.
   task automatic txn(input int k, input bit use_busy, input bit ack, input logic [7:0] dout,
                      input logic [N-1:0] late, input bit drop, output int won);
      int w, resp_off;
      bit normal, early;
      logic [N-1:0] oh;
      logic [6:0] ea;
      logic eo;
      logic [7:0] ed, er;
      w   = rr_pick(bus.req, model_rr);
      won = w;
      if (w < 0) begin
         chk("txn_has_req", 0, 1);
         return;
      end
      oh = '0;
      oh[2'(w)] = 1'b1;
      ea = bus.req_addr[7*w +: 7];
      eo = bus.req_op[2'(w)];
      ed = bus.req_wdata[8*w +: 8];
      normal   = (k >= 0 && k <= TO - 1);
      resp_off = normal ? k + 1 : TO;
      er       = (normal && eo) ? dout : 8'h00;

      tick();
      chk("gnt", bus.gnt, oh);
      chk("m_addr", bus.m_addr, ea);
      chk("m_op", bus.m_op, eo);
      chk("m_din", bus.m_din, ed);
      chk("arb_busy_issue", bus.arb_busy, 1);
      chk("m_newd_early", bus.m_newd, 0);
      tick();
      chk("m_newd", bus.m_newd, 1);
      early = 0;
      for (int j = 0; j < resp_off; j++) begin
         if (j == 1) begin
            chk("m_newd_pulse", bus.m_newd, 0);
            bus.req = bus.req | late;
         end
         if (j > 0 && (bus.rsp_valid != '0 || bus.gnt !== oh)) early = 1;
         bus.m_busy    = use_busy && (k < 0 || j < k);
         bus.m_done    = (j == k);
         bus.m_ack_err = ack;
         bus.m_dout    = dout;
         tick();
      end
      bus.m_busy = 1'b0;
      bus.m_done = 1'b0;
      chk("no_early_rsp", early, 0);
      chk("rsp_valid", bus.rsp_valid, oh);
      chk("rsp_rdata", bus.rsp_rdata, er);
      chk("rsp_err", bus.rsp_err, normal ? ack : 1'b1);
      chk("rsp_timeout", bus.rsp_timeout, !normal);
      chk("gnt_respond", bus.gnt, oh);
      if (drop) bus.req = bus.req & ~oh;
      tick();
      chk("rsp_pulse", bus.rsp_valid, 0);
      chk("gnt_drop", bus.gnt, 0);
      chk("idle_busy", bus.arb_busy, 0);
      chk("rdata_hold", bus.rsp_rdata, er);
      model_rr = (w + 1) % N;
   endtask

   initial begin
      int w, sel, k;
      bit ub;
      bus.req = '0; bus.req_addr = '0; bus.req_op = '0; bus.req_wdata = '0;
      bus.m_dout = '0; bus.m_busy = 1'b0; bus.m_done = 1'b0; bus.m_ack_err = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rdata", bus.rsp_rdata, 0);
      chk("rst_err", {bus.rsp_err, bus.rsp_timeout}, 0);
      chk("rst_busy", bus.arb_busy, 0);
      chk("rst_newd", bus.m_newd, 0);
      chk("rst_mfields", {bus.m_addr, bus.m_op, bus.m_din}, 0);
      rst = 1'b0;
      tick();

      set_fields(1, 7'h12, 1'b0, 8'hA5);
      bus.req = 4'b0010;
      txn(5, 1, 0, 8'hEE, '0, 1, w);
      chk("write_winner", w, 1);

      set_fields(2, 7'h2B, 1'b1, 8'h00);
      bus.req = 4'b0100;
      txn(4, 1, 0, 8'h3C, '0, 1, w);

      bus.req = 4'b1000;
      txn(2, 1, 0, 8'h11, '0, 1, w);

      for (int i = 0; i < N; i++) set_fields(i, 7'(8'h40 + i), i[0], 8'(8'h90 + i));
      bus.req = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         txn(1 + i, 1, 0, 8'(i), '0, 0, w);
         chk("fair_order", w, i % N);
      end

      bus.req = 4'b0001;
      txn(3, 1, 1, 8'h99, 4'b1000, 1, w);
      chk("late_req_held", bus.req, 4'b1000);

      set_fields(3, 7'h55, 1'b1, 8'h00);
      txn(TO - 1, 1, 0, 8'h5A, '0, 1, w);
      chk("late_winner", w, 3);

      bus.req = 4'b0001;
      txn(-1, 0, 0, 8'hFF, '0, 1, w);

      bus.req = 4'b0010;
      txn(0, 0, 0, 8'h22, '0, 1, w);

      // Reset while the engine is busy: no response, pointer back to 0.
      bus.req = 4'b0100;
      tick();
      chk("rstop_gnt", bus.gnt, 4'b0100);
      tick();
      bus.m_busy = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.m_busy = 1'b0;
      bus.req = '0;
      chk("rstop_gnt0", bus.gnt, 0);
      chk("rstop_busy0", bus.arb_busy, 0);
      chk("rstop_rsp0", bus.rsp_valid, 0);
      tick();
      chk("rstop_rsp1", bus.rsp_valid, 0);
      model_rr = 0;
      bus.req = 4'b1010;
      txn(2, 1, 0, 8'h44, '0, 1, w);
      chk("rstop_ptr", w, 1);

      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < N; i++) set_fields(i, 7'($urandom), 1'($urandom), 8'($urandom));
         if ($urandom_range(0, 1) == 0 || bus.req == '0) bus.req = 4'($urandom_range(1, 15));
         sel = $urandom_range(0, 9);
         case (sel)
            0:       begin k = -1;                   ub = 0; end
            1:       begin k = -1;                   ub = 1; end
            2:       begin k = TO - 1;               ub = 1; end
            3:       begin k = $urandom_range(0, 4); ub = 0; end
            default: begin k = $urandom_range(1, 12); ub = 1; end
         endcase
         txn(k, ub, 1'($urandom), 8'($urandom),
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
             1'($urandom), w);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
